mem_port_arbiter: RTL and testbench

- Sequences one shared single-port memory between instruction fetch (IF) and data access (MEM stage) in the 5-stage pipeline.
- Data requests normally win. A starvation counter guarantees that fetch is eventually served.
- Produces per-requester stall signals that the hazard logic ORs into PC/IF-ID freeze and EX/MEM hold.
- Supports cancellation of an in-flight fetch on branch/jump flush, plus a memory-ready timeout.

---
 rtl/mem_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data normally wins; a starvation counter bounds how long fetch can wait.
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int MAX_STARVE = 3,
   parameter int TIMEOUT    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          if_flush,
   output logic [DW-1:0] if_rdata,
   output logic          if_valid,
   output logic          if_stall,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_valid,
   output logic          dm_stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          timeout_err
);

   localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST  = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [7:0]     STARVE_MAX = 8'(MAX_STARVE);

   typedef enum logic [1:0] {IDLE, DATA_BUSY, FETCH_BUSY} state_t;

   state_t         state_reg, state_next;
   logic [7:0]     starve_cnt_reg, starve_cnt_next;
   logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;
   logic           discard_reg, discard_next;
   logic           mem_req_reg, mem_req_next;
   logic           mem_we_reg, mem_we_next;
   logic [AW-1:0]  mem_addr_reg, mem_addr_next;
   logic [DW-1:0]  mem_wdata_reg, mem_wdata_next;
   logic [DW-1:0]  if_rdata_reg, if_rdata_next;
   logic           if_valid_reg, if_valid_next;
   logic [DW-1:0]  dm_rdata_reg, dm_rdata_next;
   logic           dm_valid_reg, dm_valid_next;
   logic           timeout_err_reg, timeout_err_next;

   logic dm_el, if_el, timeout_hit, discard_eff;

   assign dm_el       = dm_req & ~dm_valid_reg;
   assign if_el       = if_req & ~if_valid_reg & ~if_flush;
   assign timeout_hit = (TIMEOUT > 0) ? (~mem_ready & (wait_cnt_reg == WAIT_LAST)) : 1'b0;
   // A flush in the completing cycle itself must still suppress the fetch result.
   assign discard_eff = discard_reg | if_flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         starve_cnt_reg  <= '0;
         wait_cnt_reg    <= '0;
         discard_reg     <= 1'b0;
         mem_req_reg     <= 1'b0;
         mem_we_reg      <= 1'b0;
         mem_addr_reg    <= '0;
         mem_wdata_reg   <= '0;
         if_rdata_reg    <= '0;
         if_valid_reg    <= 1'b0;
         dm_rdata_reg    <= '0;
         dm_valid_reg    <= 1'b0;
         timeout_err_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         starve_cnt_reg  <= starve_cnt_next;
         wait_cnt_reg    <= wait_cnt_next;
         discard_reg     <= discard_next;
         mem_req_reg     <= mem_req_next;
         mem_we_reg      <= mem_we_next;
         mem_addr_reg    <= mem_addr_next;
         mem_wdata_reg   <= mem_wdata_next;
         if_rdata_reg    <= if_rdata_next;
         if_valid_reg    <= if_valid_next;
         dm_rdata_reg    <= dm_rdata_next;
         dm_valid_reg    <= dm_valid_next;
         timeout_err_reg <= timeout_err_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      starve_cnt_next  = starve_cnt_reg;
      wait_cnt_next    = wait_cnt_reg;
      discard_next     = discard_reg;
      mem_req_next     = mem_req_reg;
      mem_we_next      = mem_we_reg;
      mem_addr_next    = mem_addr_reg;
      mem_wdata_next   = mem_wdata_reg;
      if_rdata_next    = if_rdata_reg;
      if_valid_next    = 1'b0;
      dm_rdata_next    = dm_rdata_reg;
      dm_valid_next    = 1'b0;
      timeout_err_next = timeout_err_reg;

      case (state_reg)
         IDLE: begin
            wait_cnt_next = '0;
            discard_next  = 1'b0;
            // The data branch is only taken with if_el set while below the limit,
            // so the increment cannot pass STARVE_MAX.
            if (dm_el && (!if_el || (starve_cnt_reg < STARVE_MAX))) begin
               state_next     = DATA_BUSY;
               mem_req_next   = 1'b1;
               mem_we_next    = dm_we;
               mem_addr_next  = dm_addr;
               mem_wdata_next = dm_wdata;
               if (if_el)
                  starve_cnt_next = starve_cnt_reg + 8'd1;
            end else if (if_el) begin
               state_next      = FETCH_BUSY;
               mem_req_next    = 1'b1;
               mem_we_next     = 1'b0;
               mem_addr_next   = if_addr;
               mem_wdata_next  = '0;
               starve_cnt_next = '0;
            end
         end

         DATA_BUSY: begin
            if (mem_ready) begin
               state_next    = IDLE;
               mem_req_next  = 1'b0;
               wait_cnt_next = '0;
               dm_valid_next = 1'b1;
               if (!mem_we_reg)
                  dm_rdata_next = mem_rdata;
            end else if (timeout_hit) begin
               state_next       = IDLE;
               mem_req_next     = 1'b0;
               wait_cnt_next    = '0;
               dm_valid_next    = 1'b1;
               dm_rdata_next    = '0;
               timeout_err_next = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt_reg + WCW'(1);
            end
         end

         FETCH_BUSY: begin
            discard_next = discard_eff;
            if (mem_ready) begin
               state_next    = IDLE;
               mem_req_next  = 1'b0;
               wait_cnt_next = '0;
               discard_next  = 1'b0;
               if (!discard_eff) begin
                  if_valid_next = 1'b1;
                  if_rdata_next = mem_rdata;
               end
            end else if (timeout_hit) begin
               state_next       = IDLE;
               mem_req_next     = 1'b0;
               wait_cnt_next    = '0;
               discard_next     = 1'b0;
               timeout_err_next = 1'b1;
               if (!discard_eff) begin
                  if_valid_next = 1'b1;
                  if_rdata_next = '0;
               end
            end else begin
               wait_cnt_next = wait_cnt_reg + WCW'(1);
            end
         end

         default: begin
            state_next   = IDLE;
            mem_req_next = 1'b0;
         end
      endcase
   end

   assign if_rdata    = if_rdata_reg;
   assign if_valid    = if_valid_reg;
   assign if_stall    = if_req & ~if_valid_reg;
   assign dm_rdata    = dm_rdata_reg;
   assign dm_valid    = dm_valid_reg;
   assign dm_stall    = dm_req & ~dm_valid_reg;
   assign mem_req     = mem_req_reg;
   assign mem_we      = mem_we_reg;
   assign mem_addr    = mem_addr_reg;
   assign mem_wdata   = mem_wdata_reg;
   assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, starvation limit, flush,
// timeout, async reset and back-to-back data requests.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0, if_flush = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_valid, if_stall;
   logic        dm_req = 1'b0, dm_we = 1'b0;
   logic [31:0] dm_addr = '0, dm_wdata = '0;
   logic [31:0] dm_rdata;
   logic        dm_valid, dm_stall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        timeout_err;

   int compared   = 0;
   int mismatched = 0;

   mem_port_arbiter #(.AW(32), .DW(32), .MAX_STARVE(3), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, grants, early;
      logic [4:0] gtype;
      logic [31:0] last_if;

      // Reset
      #3 rst = 1'b0;
      #4;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      tick;
      rst = 1'b1;
      tick;

      // Lone load, then back-to-back load with the request held through dm_valid
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
      mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
      #1;
      chk("ld_stall_T", {31'd0, dm_stall}, 32'd1);
      chk("ld_memreq_T", {31'd0, mem_req}, 32'd0);
      tick;
      chk("ld_memreq_T1", {31'd0, mem_req}, 32'd1);
      chk("ld_addr_T1", mem_addr, 32'h100);
      chk("ld_we_T1", {31'd0, mem_we}, 32'd0);
      chk("ld_stall_T1", {31'd0, dm_stall}, 32'd1);
      tick;
      chk("ld_valid_T2", {31'd0, dm_valid}, 32'd1);
      chk("ld_rdata_T2", dm_rdata, 32'hDEADBEEF);
      chk("ld_memreq_T2", {31'd0, mem_req}, 32'd0);
      chk("ld_stall_T2", {31'd0, dm_stall}, 32'd0);
      dm_addr = 32'h104; mem_rdata = 32'h11112222;
      tick;
      chk("b2b_nodouble", {31'd0, mem_req}, 32'd0);
      chk("b2b_novalid", {31'd0, dm_valid}, 32'd0);
      tick;
      chk("b2b_memreq", {31'd0, mem_req}, 32'd1);
      chk("b2b_addr", mem_addr, 32'h104);
      tick;
      chk("b2b_valid", {31'd0, dm_valid}, 32'd1);
      chk("b2b_rdata", dm_rdata, 32'h11112222);
      dm_req = 1'b0;
      tick;
      tick;

      // Starvation limit: flush blocks fetch in each data-valid cycle so both
      // requesters stay eligible together; expect D,D,D,F,D
      if_req = 1'b1; if_addr = 32'h40;
      dm_req = 1'b1; dm_addr = 32'h200;
      mem_ready = 1'b1; mem_rdata = 32'h55;
      grants = 0; early = 0; gtype = '0; last_if = '0;
      for (int i = 0; i < 40 && grants < 5; i++) begin
         tick;
         if_flush = dm_valid;
         if (if_valid) begin
            last_if = if_rdata;
            if (grants < 4) early++;
         end
         if (mem_req) begin
            gtype[grants] = (mem_addr == 32'h40);
            grants++;
         end
      end
      chk("starve_grants", grants, 32'd5);
      chk("starve_order", {27'd0, gtype}, 32'b01000);
      chk("starve_early_ifv", early, 32'd0);
      chk("starve_if_rdata", last_if, 32'h55);
      dm_req = 1'b0; if_req = 1'b0; if_flush = 1'b0;
      tick;
      tick;
      tick;

      // Flush of an in-flight fetch, then a normal fetch
      if_req = 1'b1; if_addr = 32'h80;
      mem_ready = 1'b0; mem_rdata = 32'h99;
      tick;
      chk("fl_memreq", {31'd0, mem_req}, 32'd1);
      chk("fl_addr", mem_addr, 32'h80);
      if_flush = 1'b1;
      tick;
      if_flush = 1'b0;
      tick;
      mem_ready = 1'b1;
      tick;
      chk("fl_no_valid", {31'd0, if_valid}, 32'd0);
      chk("fl_rdata_kept", if_rdata, 32'h55);
      chk("fl_memreq_drop", {31'd0, mem_req}, 32'd0);
      if_addr = 32'h90; mem_rdata = 32'hAB;
      tick;
      chk("fl_next_memreq", {31'd0, mem_req}, 32'd1);
      chk("fl_next_addr", mem_addr, 32'h90);
      chk("fl_next_stall", {31'd0, if_stall}, 32'd1);
      tick;
      chk("fl_next_valid", {31'd0, if_valid}, 32'd1);
      chk("fl_next_rdata", if_rdata, 32'hAB);
      chk("fl_next_stall0", {31'd0, if_stall}, 32'd0);
      if_req = 1'b0;
      tick;
      tick;

      // Store that never sees mem_ready
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'h1234;
      mem_ready = 1'b0;
      tick;
      chk("to_we", {31'd0, mem_we}, 32'd1);
      chk("to_wdata", mem_wdata, 32'h1234);
      n = 0;
      while (mem_req && n < 40) begin
         n++;
         tick;
      end
      chk("to_len", n, 32'd16);
      chk("to_valid", {31'd0, dm_valid}, 32'd1);
      chk("to_err", {31'd0, timeout_err}, 32'd1);
      dm_req = 1'b0; dm_we = 1'b0;
      tick;
      chk("to_valid_once", {31'd0, dm_valid}, 32'd0);
      tick;
      chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);

      // Async reset during a data transaction
      dm_req = 1'b1; dm_addr = 32'h400; mem_ready = 1'b0; mem_rdata = 32'hCAFE0001;
      tick;
      chk("ar_busy", {31'd0, mem_req}, 32'd1);
      rst = 1'b0;
      #1;
      chk("ar_memreq", {31'd0, mem_req}, 32'd0);
      chk("ar_valid", {31'd0, dm_valid}, 32'd0);
      chk("ar_err", {31'd0, timeout_err}, 32'd0);
      tick;
      mem_ready = 1'b1;
      rst = 1'b1;
      tick;
      chk("ar_new_memreq", {31'd0, mem_req}, 32'd1);
      chk("ar_new_addr", mem_addr, 32'h400);
      tick;
      chk("ar_new_valid", {31'd0, dm_valid}, 32'd1);
      chk("ar_new_rdata", dm_rdata, 32'hCAFE0001);
      dm_req = 1'b0;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
